// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and its requester / cell under test.
// master drives start, expected and the cell output; slave is the sweeper itself.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 3
) ();
  localparam int unsigned TBL_W = 32'd1 << N_IN;

  logic              start;
  logic [TBL_W-1:0]  expected;
  logic [N_IN-1:0]   stim;
  logic              dut_y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [TBL_W-1:0]  table_out;
  logic              fail_valid;
  logic [N_IN-1:0]   first_fail_idx;

  modport master (
    output start, expected, dut_y,
    input  stim, busy, done, pass, table_out, fail_valid, first_fail_idx
  );

  modport slave (
    input  start, expected, dut_y,
    output stim, busy, done, pass, table_out, fail_valid, first_fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks stim through all 2^N_IN vectors, samples the cell output SETTLE cycles
// after each update, and checks the captured truth table against a latched golden table.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus
);
  localparam int unsigned TBL_W = 32'd1 << N_IN;
  localparam int unsigned CNT_W = 4;
  localparam logic [N_IN-1:0]  LAST_VEC   = N_IN'(TBL_W - 32'd1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state;
  logic [N_IN-1:0]   stim_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TBL_W-1:0]  exp_q;
  logic [TBL_W-1:0]  table_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              fail_q;
  logic [N_IN-1:0]   ffi_q;

  logic              sample_c;
  logic [TBL_W-1:0]  table_c;
  logic [TBL_W-1:0]  diff_c;
  logic [N_IN-1:0]   ffi_c;

  // Table including this edge's sample, so the final verdict sees the last vector.
  always_comb begin
    sample_c = (state == SWEEP) && (cnt_q == CNT_W'(1));
    table_c  = table_q;
    if (sample_c) begin
      table_c[stim_q] = bus.dut_y;
    end
    diff_c = table_c ^ exp_q;
    ffi_c  = '0;
    for (int i = int'(TBL_W) - 1; i >= 0; i--) begin
      if (diff_c[i]) begin
        ffi_c = N_IN'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      ffi_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_q   <= bus.expected;
            stim_q  <= '0;
            cnt_q   <= SETTLE_CNT;
            table_q <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ffi_q   <= '0;
            state   <= SWEEP;
          end
        end
        SWEEP: begin
          table_q <= table_c;
          if (sample_c) begin
            if (stim_q != LAST_VEC) begin
              stim_q <= stim_q + 1'b1;
              cnt_q  <= SETTLE_CNT;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              stim_q <= '0;
              cnt_q  <= '0;
              done_q <= 1'b1;
              pass_q <= (diff_c == '0);
              fail_q <= (diff_c != '0);
              ffi_q  <= ffi_c;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim           = stim_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_valid     = fail_q;
  assign bus.table_out      = table_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: one sweeper with SETTLE=1 driving an xor(a,b) cell and one
// with SETTLE=3 driving majority3; a monitor per instance checks timing and results.
module tb_truth_table_sweeper;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int          e0;
    logic [7:0]  tbl;
    logic        pass;
    logic [2:0]  ffi;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   k1;
  int   k3;

  truth_table_sweeper_if #(.N_IN(3)) if1 ();
  truth_table_sweeper_if #(.N_IN(3)) if3 ();

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // stim = {a,b,c}
  assign if1.dut_y = if1.stim[2] ^ if1.stim[1];
  assign if3.dut_y = (if3.stim[2] & if3.stim[1]) | (if3.stim[2] & if3.stim[0]) |
                     (if3.stim[1] & if3.stim[0]);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Monitor for the SETTLE=1 instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (q1.size() > 0) begin
        k1 = cyc - q1[0].e0;
        if (k1 >= 0 && k1 < 8) begin
          chk("d1_busy", int'(if1.busy), 1);
          chk("d1_stim", int'(if1.stim), k1);
        end
      end
      if (if1.done) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d1_unexpected_done got=1 required=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("d1_done_latency", cyc - e.e0, 8);
          chk("d1_table", int'(if1.table_out), int'(e.tbl));
          chk("d1_pass", int'(if1.pass), int'(e.pass));
          chk("d1_fail_valid", int'(if1.fail_valid), int'(!e.pass));
          chk("d1_first_fail_idx", int'(if1.first_fail_idx), int'(e.ffi));
          chk("d1_busy_at_done", int'(if1.busy), 0);
          chk("d1_stim_at_done", int'(if1.stim), 0);
        end
      end
    end
  end

  // Monitor for the SETTLE=3 instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (q3.size() > 0) begin
        k3 = cyc - q3[0].e0;
        if (k3 >= 0 && k3 < 24) begin
          chk("d3_busy", int'(if3.busy), 1);
          chk("d3_stim", int'(if3.stim), k3 / 3);
        end
      end
      if (if3.done) begin
        if (q3.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d3_unexpected_done got=1 required=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q3.pop_front();
          chk("d3_done_latency", cyc - e.e0, 24);
          chk("d3_table", int'(if3.table_out), int'(e.tbl));
          chk("d3_pass", int'(if3.pass), int'(e.pass));
          chk("d3_fail_valid", int'(if3.fail_valid), int'(!e.pass));
          chk("d3_first_fail_idx", int'(if3.first_fail_idx), int'(e.ffi));
          chk("d3_busy_at_done", int'(if3.busy), 0);
          chk("d3_stim_at_done", int'(if3.stim), 0);
        end
      end
    end
  end

  // Issue one start pulse and push the hand-computed result.
  task automatic sweep(input int sel, input logic [7:0] exp_tbl,
                       input logic [7:0] tbl, input logic [2:0] ffi);
    exp_t e;
    @(negedge clk);
    e.e0   = cyc + 1;
    e.tbl  = tbl;
    e.pass = (tbl == exp_tbl);
    e.ffi  = ffi;
    if (sel == 1) begin
      if1.expected = exp_tbl;
      if1.start    = 1'b1;
      q1.push_back(e);
    end else begin
      if3.expected = exp_tbl;
      if3.start    = 1'b1;
      q3.push_back(e);
    end
    @(negedge clk);
    if1.start = 1'b0;
    if3.start = 1'b0;
  endtask

  task automatic wait_drain(input int sel, input int budget);
    int n = 0;
    while (((sel == 1) ? q1.size() : q3.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (((sel == 1) ? q1.size() : q3.size()) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout_dut%0d pending=%0d required=0", sel,
               (sel == 1) ? q1.size() : q3.size());
      if (sel == 1) q1.delete(); else q3.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    if1.start    = 1'b0;
    if3.start    = 1'b0;
    if1.expected = 8'h00;
    if3.expected = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(if1.busy) + int'(if3.busy), 0);
    chk("rst_done", int'(if1.done) + int'(if3.done), 0);
    chk("rst_stim", int'(if1.stim) + int'(if3.stim), 0);
    chk("rst_pass", int'(if1.pass) + int'(if3.pass), 0);
    chk("rst_fail_valid", int'(if1.fail_valid) + int'(if3.fail_valid), 0);
    chk("rst_table", int'(if1.table_out) + int'(if3.table_out), 0);
    chk("rst_ffi", int'(if1.first_fail_idx) + int'(if3.first_fail_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // xor(a,b): pass, then mismatches at the top vector and a middle vector
    sweep(1, 8'h3C, 8'h3C, 3'd0);
    wait_drain(1, 40);
    sweep(1, 8'hBC, 8'h3C, 3'd7);
    wait_drain(1, 40);
    sweep(1, 8'h7C, 8'h3C, 3'd6);
    wait_drain(1, 40);

    // majority3 with SETTLE=3: pass and two wrong golden tables
    sweep(3, 8'hE8, 8'hE8, 3'd0);
    wait_drain(3, 60);
    sweep(3, 8'hE9, 8'hE8, 3'd0);
    wait_drain(3, 60);
    sweep(3, 8'hEC, 8'hE8, 3'd2);
    wait_drain(3, 60);

    // golden table changed mid-sweep must not affect the verdict
    sweep(3, 8'hE8, 8'hE8, 3'd0);
    repeat (4) @(negedge clk);
    if3.expected = 8'h00;
    wait_drain(3, 60);
    repeat (3) @(negedge clk);
    chk("d3_pass_hold", int'(if3.pass), 1);
    chk("d3_table_hold", int'(if3.table_out), 32'hE8);

    // start while busy is ignored
    sweep(3, 8'hE8, 8'hE8, 3'd0);
    repeat (3) @(negedge clk);
    if3.expected = 8'h00;
    if3.start    = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    wait_drain(3, 60);

    // start held high: three back-to-back sweeps, done every 9 cycles
    begin
      exp_t e;
      @(negedge clk);
      e.tbl  = 8'h3C;
      e.pass = 1'b1;
      e.ffi  = 3'd0;
      e.e0   = cyc + 1;
      q1.push_back(e);
      e.e0   = cyc + 10;
      q1.push_back(e);
      e.e0   = cyc + 19;
      q1.push_back(e);
      if1.expected = 8'h3C;
      if1.start    = 1'b1;
      repeat (21) @(negedge clk);
      if1.start = 1'b0;
      wait_drain(1, 40);
      repeat (4) @(negedge clk);
    end

    // asynchronous reset in the middle of a sweep
    sweep(1, 8'h3C, 8'h3C, 3'd0);
    for (int n = 0; n < 30 && if1.stim != 3'd4; n++) @(negedge clk);
    chk("d1_reached_stim4", int'(if1.stim), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(if1.busy), 0);
    chk("arst_stim", int'(if1.stim), 0);
    chk("arst_table", int'(if1.table_out), 0);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(1, 8'h3C, 8'h3C, 3'd0);
    wait_drain(1, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
